add8u_share_arb: RTL and testbench
==================================

Name: add8u_share_arb

Overview:
Round-robin arbiter and two-stage sequencer that shares one combinational 8-bit unsigned adder among NREQ requesters. These are typically approximate add8u variants. Each requester presents an operand pair via valid/ready. The block registers the granted pair onto the adder inputs, captures the 9-bit adder output with the requester ID, and returns it on a single backpressured response channel. It sits between the requesting datapath units and the adder instance, which is external so that any add8u variant can be bound in.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
IDW, 2, width of requester ID; must equal max(1, ceil(log2(NREQ))).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NREQ  bit i = requester i has an operand pair.
req_ready  out  NREQ  bit i = pair from requester i accepted this cycle; combinational.
req_a  in  8*NREQ  operand A; requester i at [8i+7:8i].
req_b  in  8*NREQ  operand B; same packing.
add_a  out  8  registered operand A to shared adder.
add_b  out  8  registered operand B to shared adder.
add_o  in  9  combinational sum from shared adder (O[8:0]).
rsp_valid  out  1  response available.
rsp_ready  in  1  downstream accepts response.
rsp_sum  out  9  captured add_o.
rsp_id  out  IDW  index of originating requester.
done_cnt  out  16  number of completed responses; wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at an edge): op_vld=0, add_a=0, add_b=0, op_id=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, done_cnt=0.
- Reset mid-operation discards any in-flight operation with no response. req_ready is 0 in every cycle where rst=1.
- Stage S1 (issue): registers op_vld, add_a, add_b, op_id. add_a/add_b drive the adder directly.
- Stage S2 (result): registers rsp_valid, rsp_sum, rsp_id.
- s2_stall = rsp_valid & ~rsp_ready.
- s1_adv = op_vld & ~s2_stall. On s1_adv, S2 loads rsp_sum<=add_o, rsp_id<=op_id, rsp_valid<=1.
- When S2 is not stalled and S1 is not advancing, rsp_valid<=0 at the next edge.
- s1_free = ~op_vld | ~s2_stall.
- Arbitration: winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner] = s1_free & ~rst; all other bits are 0.
  - At most one bit of req_ready is high per cycle.
- Accept (req_valid[w] & req_ready[w]): S1 loads add_a<=req_a[w], add_b<=req_b[w], op_id<=w, op_vld<=1, and rr_ptr<=(w+1) mod NREQ.
- If s1_free and there is no accept, op_vld<=0 and add_a/add_b hold their values. This keeps adder power low.
- Latency: accepted at edge t, rsp_valid=1 from edge t+1 and consumed at earliest on edge t+2; one cycle in S1 and one in S2. Throughput is one operation per cycle when rsp_ready=1.
- Backpressure: when S2 is stalled, S1 holds. When S1 is full and S2 is stalled, req_ready is all 0. No operation is ever dropped or duplicated.
- Simultaneous S2 drain and S1 advance in the same cycle is legal: S2 reloads with no bubble.
- Fairness: a requester holding req_valid=1 is granted within NREQ accepts.
- req_valid may drop without handshake (no ordering requirement on requesters). Operands must be stable only in the accept cycle.
- done_cnt increments on each rsp_valid & rsp_ready and wraps 16'hFFFF -> 16'h0000.
- rsp_sum carries the adder output unmodified. The block performs no arithmetic on it and has no carry-in/out chaining.

Test Plan:
- Reset/idle: assert rst 2 cycles with all req_valid=1. Required: req_ready=0 while rst; after release, rsp_valid=0, done_cnt=0, first grant to requester 0.
- Single op, exact adder bound: req0 a=200 b=100, accepted at edge t. Required: rsp_valid at t+1, rsp_sum=9'h12C, rsp_id=0, done_cnt=1 after consume. With add8u_07X bound instead, rsp_sum equals that model's output for (200,100).
- Round-robin: all 4 requesters valid continuously, rsp_ready=1. Required: grant order 0,1,2,3,0,1 …, one accept per cycle, rsp_id stream matches grant order delayed 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with req0 and req2 streaming. Required: at most 2 ops in flight, req_ready=0 once S1 and S2 are full, and all ops later emerge in order with correct sums (e.g. 255+255 -> 9'h1FE, 0+0 -> 0).
- Reset mid-operation: rst during a stall with S1 and S2 full. Required: rsp_valid=0 next cycle, no stale response emitted, rr_ptr=0.
- Counter wrap: force 65 537 completions (or preload via a bench fast path). Required: done_cnt reads 1 after wrap.

Source files
------------

// File: rtl/add8u_share_arb_if.sv
// ---------------------------------------------------------------------------
// add8u_share_arb_if
// Bundle of every non-clock/reset signal of add8u_share_arb.
//
//   req_valid / req_ready  per-requester handshake (bit i = requester i)
//   req_a / req_b          packed operands, requester i at [8i+7:8i]
//   add_a / add_b          registered operands driven to the shared adder
//   add_o                  9-bit combinational sum returned by the adder
//   rsp_valid / rsp_ready  single backpressured response channel
//   rsp_sum / rsp_id       captured sum and originating requester index
//   done_cnt               completed responses, wraps modulo 2^16
//
// The "master" modport is the environment side: the requesters, the external
// adder instance and the response consumer. The "slave" modport is the
// arbiter itself.
// ---------------------------------------------------------------------------
interface add8u_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [7:0]        add_a;
    logic [7:0]        add_b;
    logic [8:0]        add_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [8:0]        rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       done_cnt;

    modport master (
        output req_valid, req_a, req_b, add_o, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, done_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, add_o, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, done_cnt
    );
endinterface

// File: rtl/add8u_share_arb.sv
// ---------------------------------------------------------------------------
// add8u_share_arb
// Round-robin arbiter plus two-stage sequencer sharing one external 8-bit
// unsigned adder (any add8u variant) among NREQ requesters.
//
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   add8u_share_arb_if.slave (request, adder and response signals)
//
// Stage S1 holds the granted operand pair on add_a/add_b, stage S2 captures
// add_o together with the requester id. Accepted at edge t, the response is
// visible from edge t+1; one operation per cycle when rsp_ready stays high.
// NREQ and IDW must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module add8u_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic            clk,
    input logic            rst,
    add8u_share_arb_if.slave bus
);

    logic           op_vld;
    logic [7:0]     add_a_q;
    logic [7:0]     add_b_q;
    logic [IDW-1:0] op_id;
    logic           rsp_valid_q;
    logic [8:0]     rsp_sum_q;
    logic [IDW-1:0] rsp_id_q;
    logic [IDW-1:0] rr_ptr;
    logic [15:0]    done_cnt_q;

    logic           s2_stall;
    logic           s1_adv;
    logic           s1_free;
    logic           found;
    logic           accept;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;
    logic [NREQ-1:0] req_ready_c;

    // Pipeline control: S2 stalls only while holding an unconsumed response,
    // and S1 can take a new pair whenever it is empty or can move into S2.
    assign s2_stall = rsp_valid_q & ~bus.rsp_ready;
    assign s1_adv   = op_vld & ~s2_stall;
    assign s1_free  = ~op_vld | ~s2_stall;
    assign accept   = found & s1_free & ~rst;

    // Round-robin search starting at rr_ptr; the first valid requester in
    // rotating order wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    assign next_ptr = (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);

    // One-hot ready towards the winner only; forced low during reset.
    always_comb begin
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[winner] = 1'b1;
        end
    end

    // Both pipeline stages and the completion counter. When S1 frees up with
    // nothing to accept, the operand registers keep their old values so the
    // adder inputs do not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_vld      <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            op_id       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rr_ptr      <= '0;
            done_cnt_q  <= '0;
        end else begin
            if (s1_free) begin
                if (accept) begin
                    add_a_q <= bus.req_a[8*int'(winner) +: 8];
                    add_b_q <= bus.req_b[8*int'(winner) +: 8];
                    op_id   <= winner;
                    op_vld  <= 1'b1;
                    rr_ptr  <= next_ptr;
                end else begin
                    op_vld  <= 1'b0;
                end
            end

            if (s1_adv) begin
                rsp_valid_q <= 1'b1;
                rsp_sum_q   <= bus.add_o;
                rsp_id_q    <= op_id;
            end else if (!s2_stall) begin
                rsp_valid_q <= 1'b0;
            end

            if (rsp_valid_q && bus.rsp_ready) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_add8u_share_arb.sv
// ---------------------------------------------------------------------------
// tb_add8u_share_arb
// Scoreboard bench for add8u_share_arb with an exact 9-bit adder bound to
// the shared adder port. A request monitor predicts the round-robin winner,
// checks req_ready against it and queues the expected {sum, id}; a response
// monitor pops and compares on every rsp_valid & rsp_ready.
// ---------------------------------------------------------------------------
module tb_add8u_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [8:0]     sum;
        logic [IDW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    add8u_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    add8u_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Exact add8u bound to the shared adder port.
    assign bus.add_o = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    always #5 clk = ~clk;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    exp_t       sb[$];
    logic [8:0] op_s [NREQ];
    int         exp_ptr   = 0;
    int         n_acc     = 0;
    int         n_cons    = 0;
    int         mw;
    exp_t       got;

    // Single comparison point; every failure prints one FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive reset and handshake inputs just after the next rising edge.
    task automatic applyStimulus(input logic [NREQ-1:0] vld, input logic rdy,
                                 input logic rst_v);
        @(posedge clk);
        #1;
        rst           = rst_v;
        bus.req_valid = vld;
        bus.rsp_ready = rdy;
    endtask

    // Present an operand pair on requester i with its hand-computed sum.
    task automatic setOperand(input int i, input logic [7:0] a, input logic [7:0] b,
                              input logic [8:0] s);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
        op_s[i]             = s;
    endtask

    // Wait, bounded, until nothing is queued or in flight, then check the
    // completion counter against the responses seen.
    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_drain_in_time"}, 32'(k < 200), 32'd1);
        @(negedge clk);
        checkOutput({name, "_done_cnt"}, 32'(bus.done_cnt), 32'(n_cons[15:0]));
    endtask

    // Request monitor: predicts the round-robin winner from its own pointer
    // and queues the expected response for each accepted pair.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_ptr = 0;
            n_acc   = 0;
        end else if (bus.req_ready != '0) begin
            mw = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (mw < 0 && bus.req_valid[(exp_ptr + k) % NREQ]) begin
                    mw = (exp_ptr + k) % NREQ;
                end
            end
            if (mw < 0) begin
                checkOutput("grant_without_valid", 32'(bus.req_ready), 32'd0);
            end else begin
                checkOutput("grant", 32'(bus.req_ready), 32'd1 << mw);
                sb.push_back('{sum: op_s[mw], id: IDW'(mw)});
                exp_ptr = (mw + 1) % NREQ;
                n_acc++;
            end
        end
    end

    // Response monitor: every consumed response must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            n_cons = 0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_rsp: got sum 0x%0h id %0d, expected no response",
                         bus.rsp_sum, bus.rsp_id);
            end else begin
                got = sb.pop_front();
                checkOutput("rsp_sum", 32'(bus.rsp_sum), 32'(got.sum));
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(got.id));
            end
            n_cons++;
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int start_acc;
    int k;

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        setOperand(0, 8'd200, 8'd100, 9'h12C);
        setOperand(1, 8'd17,  8'd34,  9'h033);
        setOperand(2, 8'd128, 8'd128, 9'h100);
        setOperand(3, 8'd99,  8'd250, 9'h15D);

        // Reset held two cycles with every requester asking.
        $display("[TB] reset with all requesters valid");
        applyStimulus('1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("ready_in_reset_0", 32'(bus.req_ready), 32'd0);
        applyStimulus('1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("ready_in_reset_1", 32'(bus.req_ready), 32'd0);

        // Single operation from requester 0, with latency checks.
        $display("[TB] single op 200+100");
        applyStimulus(4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idle_done_cnt", 32'(bus.done_cnt), 32'd0);
        checkOutput("first_grant", 32'(bus.req_ready), 32'b0001);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("latency_not_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("single_sum", 32'(bus.rsp_sum), 32'h12C);
        checkOutput("single_id", 32'(bus.rsp_id), 32'd0);
        drain("single");
        checkOutput("single_done_one", 32'(bus.done_cnt), 32'd1);

        // All four requesters streaming: one accept per cycle in rotation.
        $display("[TB] round robin, all valid");
        applyStimulus(4'b1111, 1'b1, 1'b0);
        start_acc = n_acc;
        repeat (9) @(posedge clk);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("rr_accepts_per_cycle", 32'(n_acc - start_acc), 32'd10);
        drain("rr");

        // Backpressure: only two operations may enter while the output stalls.
        $display("[TB] backpressure with req0 and req2");
        setOperand(0, 8'd255, 8'd255, 9'h1FE);
        setOperand(2, 8'd0,   8'd0,   9'h000);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        start_acc = n_acc;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
        checkOutput("bp_rsp_held", 32'(bus.rsp_valid), 32'd1);
        checkOutput("bp_in_flight", 32'(n_acc - start_acc), 32'd2);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        drain("bp");

        // Reset while both stages are full and stalled.
        $display("[TB] reset mid-operation");
        applyStimulus(4'b0101, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("ready_in_reset_mid", 32'(bus.req_ready), 32'd0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("post_reset_done_cnt", 32'(bus.done_cnt), 32'd0);
        checkOutput("post_reset_grant", 32'(bus.req_ready), 32'b0001);
        repeat (5) @(posedge clk);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        drain("mid_reset");

        // Completion counter wrap: 65537 responses from a fresh reset.
        $display("[TB] counter wrap stream");
        applyStimulus(4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        k = 0;
        while (n_acc < 65537 && k < 70000) begin
            @(posedge clk);
            #1;
            k++;
        end
        bus.req_valid = '0;
        checkOutput("wrap_issued", 32'(n_acc), 32'd65537);
        drain("wrap");
        checkOutput("wrap_done_cnt", 32'(bus.done_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
